seg_scan_sched: RTL

Digit-scan scheduler for the 74HC595-based 8-digit seven-segment display. It time-multiplexes a 32-bit hex value across up to 8 digits, one digit per refresh slot. For each digit it decodes the nibble to a segment pattern and builds a 16-bit frame of segment byte plus one-hot digit select. It hands each frame to the downstream 595 serializer over a valid/ready handshake. The shadowed value is updated only at scan boundaries, so the display never shows a mix of old and new digits within one scan.

---
 rtl/seg_scan_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_sched.sv
// Digit-scan scheduler for a 595-driven 8-digit seven-segment display.
// Time-multiplexes a shadowed 32-bit hex value and offers one {seg, sel} frame per refresh slot.
module seg_scan_sched #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned REFRESH_CYC    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank,
  input  logic        en,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        scan_done,
  output logic [2:0]  digit_idx
);

  localparam int unsigned CntW = (REFRESH_CYC > 2) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [7:0]  SelMask = 8'((16'd1 << DIGITS) - 16'd1);
  localparam logic [2:0]  LastIdx = 3'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StWait} state_e;

  state_e          state_q, state_d;
  logic [31:0]     data_q, data_d;
  logic [7:0]      dp_q, dp_d;
  logic [7:0]      blank_q, blank_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [15:0]     frame_q, frame_d;
  logic            done_q, done_d;

  logic [3:0] nibble;
  logic [7:0] seg_raw;
  logic [7:0] seg;
  logic [7:0] sel;

  // Segment decode for the digit currently indexed, bit order {dp,g,f,e,d,c,b,a}.
  always_comb begin
    nibble = data_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0:    seg_raw = 8'h3F;
      4'h1:    seg_raw = 8'h06;
      4'h2:    seg_raw = 8'h5B;
      4'h3:    seg_raw = 8'h4F;
      4'h4:    seg_raw = 8'h66;
      4'h5:    seg_raw = 8'h6D;
      4'h6:    seg_raw = 8'h7D;
      4'h7:    seg_raw = 8'h07;
      4'h8:    seg_raw = 8'h7F;
      4'h9:    seg_raw = 8'h6F;
      4'hA:    seg_raw = 8'h77;
      4'hB:    seg_raw = 8'h7C;
      4'hC:    seg_raw = 8'h39;
      4'hD:    seg_raw = 8'h5E;
      4'hE:    seg_raw = 8'h79;
      default: seg_raw = 8'h71;
    endcase
    seg = blank_q[idx_q] ? 8'h00 : (seg_raw | {dp_q[idx_q], 7'b0});
    if (SEG_ACTIVE_LOW) begin
      seg = ~seg;
    end
    sel = (8'd1 << idx_q) & SelMask;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          data_d  = data_in;
          dp_d    = dp_in;
          blank_d = blank;
          idx_d   = 3'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        frame_d = {seg, sel};
        state_d = StSend;
      end
      StSend: begin
        if (frame_ready) begin
          if (idx_q == LastIdx) begin
            // Scan boundary: the only point where new display content is taken.
            done_d  = 1'b1;
            idx_d   = 3'd0;
            data_d  = data_in;
            dp_d    = dp_in;
            blank_d = blank;
          end else begin
            idx_d = idx_q + 3'd1;
          end
          cnt_d   = CntW'(REFRESH_CYC - 3);
          state_d = en ? StWait : StIdle;
        end
      end
      StWait: begin
        if (!en) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  // Decoded from state so an asynchronous reset withdraws the frame at once.
  assign frame_valid = (state_q == StSend);
  assign frame_data  = frame_q;
  assign scan_done   = done_q;
  assign digit_idx   = idx_q;

endmodule
